// File: rtl/modbus_pkg.sv
// Shared types and constants for the register-group fan-out bus.
package modbus_pkg;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RESP,
    RD_HOLD
  } mb_fanout_state_t;

  // Select width: ceil(log2(n)) but never below one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/modbus_fanout_if.sv
// Configurator-side master port of the register-group bus.
interface modbus_fanout_if #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_SIZE = 32
);
  logic [ADDR_W-1:0]    m_waddr;
  logic [DATA_SIZE-1:0] m_wdata;
  logic                 m_awvalid;
  logic                 m_dwvalid;
  logic                 m_wready;
  logic [ADDR_W-1:0]    m_raddr;
  logic                 m_arvalid;
  logic [DATA_SIZE-1:0] m_rdata;
  logic                 m_drvalid;
  logic                 m_rready;

  modport master (
    output m_waddr, m_wdata, m_awvalid, m_dwvalid, m_raddr, m_arvalid, m_rready,
    input  m_wready, m_rdata, m_drvalid
  );

  modport slave (
    input  m_waddr, m_wdata, m_awvalid, m_dwvalid, m_raddr, m_arvalid, m_rready,
    output m_wready, m_rdata, m_drvalid
  );
endinterface

// File: rtl/mb_timeout_timer.sv
// Wait-cycle counter; expired_c flags the last allowed waiting cycle.
module mb_timeout_timer #(
  parameter  int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/modbus_fanout.sv
// One master port fanned out to NUM_SLAVES register groups, one transaction in flight.
// Optional MODBUS_FANOUT_STATS_EN adds err_count / err_sel error statistics ports.
module modbus_fanout
  import modbus_pkg::*;
#(
  parameter  int unsigned NUM_SLAVES     = 4,
  parameter  int unsigned SLV_ADDR_SIZE  = 4,
  parameter  int unsigned DATA_SIZE      = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned SEL_W          = clog2_min1(NUM_SLAVES)
) (
  input  logic                             clk,
  input  logic                             rst,
  modbus_fanout_if.slave                   m,
  output logic [SLV_ADDR_SIZE-1:0]         s_waddr,
  output logic [DATA_SIZE-1:0]             s_wdata,
  output logic [NUM_SLAVES-1:0]            s_awvalid,
  output logic [NUM_SLAVES-1:0]            s_dwvalid,
  input  logic [NUM_SLAVES-1:0]            s_wready,
  output logic [SLV_ADDR_SIZE-1:0]         s_raddr,
  output logic [NUM_SLAVES-1:0]            s_arvalid,
  input  logic [NUM_SLAVES*DATA_SIZE-1:0]  s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_drvalid,
  output logic [NUM_SLAVES-1:0]            s_rready,
  output logic                             timeout_err
`ifdef MODBUS_FANOUT_STATS_EN
  ,
  output logic [15:0]                      err_count,
  output logic [SEL_W-1:0]                 err_sel
`endif
);

  localparam int unsigned           ADDR_W   = SLV_ADDR_SIZE + SEL_W;
  localparam logic [DATA_SIZE-1:0]  ERR_WORD = DATA_SIZE'(ERR_DATA);
  localparam logic [NUM_SLAVES-1:0] SLV0_OH  = NUM_SLAVES'(1);

  mb_fanout_state_t       state;
  logic [SEL_W-1:0]       sel_q;
  logic [SEL_W-1:0]       wsel_c;
  logic [SEL_W-1:0]       rsel_c;
  logic                   wsel_bad_c;
  logic                   rsel_bad_c;
  logic [NUM_SLAVES-1:0]  sel_oh_c;
  logic                   wr_hit_c;
  logic                   rd_hit_c;
  logic                   expired_c;

  assign wsel_c     = m.m_waddr[ADDR_W-1 -: SEL_W];
  assign rsel_c     = m.m_raddr[ADDR_W-1 -: SEL_W];
  assign wsel_bad_c = {1'b0, wsel_c} >= (SEL_W + 1)'(NUM_SLAVES);
  assign rsel_bad_c = {1'b0, rsel_c} >= (SEL_W + 1)'(NUM_SLAVES);
  assign sel_oh_c   = SLV0_OH << sel_q;
  // Responses only count from the selected slave while its own strobe is up
  assign wr_hit_c   = |(s_wready & s_awvalid & sel_oh_c);
  assign rd_hit_c   = |(s_drvalid & s_arvalid & sel_oh_c);

  mb_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == IDLE),
    .enable    ((state == WR) || (state == RD)),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_q       <= '0;
      s_waddr     <= '0;
      s_wdata     <= '0;
      s_raddr     <= '0;
      s_awvalid   <= '0;
      s_dwvalid   <= '0;
      s_arvalid   <= '0;
      s_rready    <= '0;
      m.m_wready  <= 1'b0;
      m.m_rdata   <= '0;
      m.m_drvalid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      m.m_wready  <= 1'b0;
      s_rready    <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m.m_awvalid && m.m_dwvalid) begin
            sel_q <= wsel_c;
            if (wsel_bad_c) begin
              m.m_wready  <= 1'b1;
              timeout_err <= 1'b1;
              state       <= RESP;
            end else begin
              s_waddr <= m.m_waddr[SLV_ADDR_SIZE-1:0];
              s_wdata <= m.m_wdata;
              state   <= WR;
            end
          end else if (m.m_arvalid) begin
            sel_q <= rsel_c;
            if (rsel_bad_c) begin
              m.m_rdata   <= ERR_WORD;
              m.m_drvalid <= 1'b1;
              timeout_err <= 1'b1;
              state       <= RD_HOLD;
            end else begin
              s_raddr <= m.m_raddr[SLV_ADDR_SIZE-1:0];
              state   <= RD;
            end
          end
        end
        WR: begin
          if (s_awvalid == '0) begin
            s_awvalid <= sel_oh_c;
            s_dwvalid <= sel_oh_c;
          end else if (wr_hit_c || expired_c) begin
            s_awvalid   <= '0;
            s_dwvalid   <= '0;
            m.m_wready  <= 1'b1;
            timeout_err <= !wr_hit_c;
            state       <= RESP;
          end
        end
        RD: begin
          if (s_arvalid == '0) begin
            s_arvalid <= sel_oh_c;
          end else if (rd_hit_c) begin
            s_arvalid   <= '0;
            s_rready    <= sel_oh_c;
            m.m_rdata   <= s_rdata[32'(sel_q) * DATA_SIZE +: DATA_SIZE];
            m.m_drvalid <= 1'b1;
            state       <= RD_HOLD;
          end else if (expired_c) begin
            s_arvalid   <= '0;
            m.m_rdata   <= ERR_WORD;
            m.m_drvalid <= 1'b1;
            timeout_err <= 1'b1;
            state       <= RD_HOLD;
          end
        end
        RESP: state <= IDLE;
        RD_HOLD: begin
          if (m.m_rready) begin
            m.m_drvalid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MODBUS_FANOUT_STATS_EN
  // sel_q still holds the failing select while the error pulse is up
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
      err_sel   <= '0;
    end else if (timeout_err) begin
      err_sel <= sel_q;
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule
